// File: rtl/hdc_msg_streamer.sv
// hdc_msg_streamer: holds one text message (up to MAX_LEN characters plus
// its length and label) and streams it, one character per handshake, to the
// tokenizer input of the HDC classifier datapath.
//
// Handshake: a character transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data, out_index,
// out_last and out_label hold steady until that transfer, and out_valid
// never falls without a transfer.
module hdc_msg_streamer #(
    parameter int CHAR_W  = 32,
    parameter int MAX_LEN = 160,
    parameter int LEN_W   = 8
) (
    input  logic              clk,
    input  logic              reset,       // asynchronous, active-low
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              msg_label,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_index,
    output logic              out_last,
    output logic              out_label,
    output logic [1:0]        dbg_state    // current FSM state, for checkers
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CHAR_W-1:0] mem [MAX_LEN];
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              label_q, label_d;
    logic              err_q, err_d;
    logic              len_ok;
    logic              is_last;

    // A message is accepted only when it has at least one character and fits the buffer.
    assign len_ok  = (msg_len != '0) && (msg_len <= LEN_W'(MAX_LEN));
    assign is_last = (idx_q == (len_q - LEN_W'(1)));

    // Message buffer: no reset, contents persist; writable only while idle.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && wr_en && wr_addr < LEN_W'(MAX_LEN)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State, index, latched length/label and the registered err_len pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            label_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            label_q <= label_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept/reject start, advance on each transfer, one DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        label_d = label_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = msg_len;
                        label_d = msg_label;
                        idx_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: stream fields are forced to zero outside STREAM.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err_len   = err_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        out_label = label_q;
        dbg_state = state_q;
        if (state_q == S_STREAM) begin
            out_valid = 1'b1;
            out_data  = mem[idx_q];
            out_index = idx_q;
            out_last  = is_last;
        end
    end

endmodule

// File: tb/tb_hdc_msg_streamer.sv
// Bench for hdc_msg_streamer: directed scenarios plus randomized messages,
// checked by a monitor against a queue of expected characters.
module tb_hdc_msg_streamer;

    localparam int CHAR_W  = 32;
    localparam int MAX_LEN = 160;
    localparam int LEN_W   = 8;
    localparam int BW      = 2 + LEN_W + CHAR_W;  // {label, last, index, data}

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [LEN_W-1:0]  wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic              start;
    logic [LEN_W-1:0]  msg_len;
    logic              msg_label;
    logic              busy;
    logic              done;
    logic              err_len;
    logic              out_valid;
    logic              out_ready;
    logic [CHAR_W-1:0] out_data;
    logic [LEN_W-1:0]  out_index;
    logic              out_last;
    logic              out_label;
    logic [1:0]        dbg_state;

    // reference model: the message text as a plain array, expected beats as a queue
    logic [CHAR_W-1:0] model_mem [MAX_LEN];
    logic [BW-1:0]     exp_q [$];
    logic              last_label;
    int                checks;
    int                failures;
    bit                ready_rand;
    int                ready_pat [$];

    hdc_msg_streamer #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .msg_len(msg_len), .msg_label(msg_label),
        .busy(busy), .done(done), .err_len(err_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .out_label(out_label),
        .dbg_state(dbg_state)
    );

    // clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // consumer ready: explicit pattern first, else random or always-high
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_pat.size() > 0) out_ready = ready_pat.pop_front() != 0;
            else if (ready_rand)      out_ready = $urandom_range(0, 1) != 0;
            else                      out_ready = 1'b1;
        end
    end

    // monitor: pops an expected beat on every transfer, checks hold and done timing
    initial begin
        logic          prev_valid;
        logic          prev_hs;
        logic          last_hs_prev;
        logic          hs;
        logic [BW-1:0] beat;
        logic [BW-1:0] prev_beat;
        prev_valid   = 1'b0;
        prev_hs      = 1'b0;
        last_hs_prev = 1'b0;
        prev_beat    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid   = 1'b0;
                prev_hs      = 1'b0;
                last_hs_prev = 1'b0;
            end else begin
                beat = {out_label, out_last, out_index, out_data};
                chk("done_after_last", done, last_hs_prev);
                chk("busy_vs_phase", busy, out_valid | done);
                if (prev_valid && !prev_hs) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_beat", beat, prev_beat);
                end
                if (!out_valid) chk("idle_fields_zero", {out_last, out_index, out_data}, 0);
                hs = out_valid && out_ready;
                if (hs) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", beat, 0);
                    else                   chk("beat", beat, exp_q.pop_front());
                end
                prev_valid   = out_valid;
                prev_hs      = hs;
                prev_beat    = beat;
                last_hs_prev = hs && out_last;
            end
        end
    end

    // driver tasks
    task automatic write_char(input int a, input logic [CHAR_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = LEN_W'(a);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (a < MAX_LEN) model_mem[a] = d;
    endtask

    task automatic expect_msg(input int len, input logic label);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({label, 1'(i == len - 1), LEN_W'(i), model_mem[i]});
        end
    endtask

    // issues start (with any write already set up on wr_*) for one cycle
    task automatic start_msg(input int len, input logic label);
        bit ok;
        ok        = (len >= 1) && (len <= MAX_LEN);
        start     = 1'b1;
        msg_len   = LEN_W'(len);
        msg_label = label;
        if (wr_en && wr_addr < MAX_LEN) model_mem[wr_addr] = wr_data;
        if (ok) begin
            expect_msg(len, label);
            last_label = label;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        if (ok) begin
            chk("start_accept", {busy, out_valid, err_len}, 3'b110);
        end else begin
            chk("reject_pulse", {err_len, busy, out_valid}, 3'b100);
            @(posedge clk);
            #1;
            chk("reject_clear", {err_len, busy, out_valid}, 3'b000);
        end
    endtask

    // counts cycles from the start edge until done, then checks return to idle
    task automatic wait_done(input int budget, output int n);
        n = 1;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        chk("back_idle", {busy, out_label}, {1'b0, last_label});
    endtask

    task automatic check_reset_zero(input string name);
        chk(name, {busy, done, err_len, out_valid, out_last, out_label, out_index, out_data}, 0);
    endtask

    initial begin
        int n;
        int len;
        logic lab;
        checks     = 0;
        failures   = 0;
        ready_rand = 1'b0;
        last_label = 1'b0;
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        start      = 1'b0;
        msg_len    = '0;
        msg_label  = 1'b0;
        #12;
        check_reset_zero("reset_outputs");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // "abc", label spam, ready high
        write_char(0, 32'h61);
        write_char(1, 32'h62);
        write_char(2, 32'h63);
        start_msg(3, 1'b1);
        wait_done(100, n);
        chk("latency_abc", n, 4);

        // same message with ready pattern 1,0,0,1,1
        @(negedge clk);
        ready_pat = '{1, 0, 0, 1, 1};
        start_msg(3, 1'b1);
        wait_done(100, n);
        chk("latency_abc_bp", n, 6);

        // rejected lengths
        start_msg(0, 1'b0);
        start_msg(161, 1'b1);

        // full-length message, buf[i] = i
        for (int i = 0; i < MAX_LEN; i++) write_char(i, CHAR_W'(i));
        start_msg(MAX_LEN, 1'b0);
        wait_done(400, n);
        chk("latency_full", n, MAX_LEN + 1);

        // write and start during STREAM are ignored
        write_char(5, 32'hA5A5_A5A5);
        ready_rand = 1'b1;
        start_msg(8, 1'b1);
        wr_en     = 1'b1;
        wr_addr   = 8'd5;
        wr_data   = 32'hDEAD_BEEF;
        start     = 1'b1;
        msg_len   = 8'd3;
        msg_label = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
        chk("stream_start_ignored", {busy, err_len}, 2'b10);
        wait_done(200, n);
        ready_rand = 1'b0;
        start_msg(8, 1'b1);
        wait_done(100, n);
        chk("latency_rerun", n, 9);

        // write in the same cycle as start: stream sees the new value
        wr_en   = 1'b1;
        wr_addr = 8'd0;
        wr_data = 32'h0000_0077;
        start_msg(4, 1'b0);
        wait_done(100, n);

        // reset after two of five beats aborts; buffer survives
        start_msg(5, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_zero("midstream_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_zero("reset_held");
        @(negedge clk);
        reset = 1'b1;
        last_label = 1'b0;
        @(posedge clk);
        #1;
        start_msg(5, 1'b1);
        wait_done(100, n);
        chk("latency_after_reset", n, 6);

        // randomized messages with random backpressure
        ready_rand = 1'b1;
        repeat (20) begin
            repeat ($urandom_range(0, 3)) write_char($urandom_range(0, MAX_LEN - 1), $urandom);
            lab = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 5) == 0) len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(161, 255);
            else                           len = $urandom_range(1, 24);
            start_msg(len, lab);
            if (len >= 1 && len <= MAX_LEN) wait_done(500, n);
        end
        ready_rand = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdc_msg_streamer.md
# hdc_msg_streamer

Message transmitter for the HDC spam/ham classifier. It holds one text message of up to MAX_LEN characters with its length and label, then streams the characters one per handshake to the tokenizer input of the classifier datapath. It marks the final character and carries the label alongside the stream. It replaces file-driven stimulus with a synthesizable source, so the classifier can be driven on-chip.

## Interface
- CHAR_W, 32: bits per character word
- MAX_LEN, 160: maximum characters per message
- LEN_W, 8: width of length and index fields; must satisfy 2^LEN_W > MAX_LEN

- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  buffer write strobe; honoured only in IDLE
- wr_addr  in  LEN_W  buffer write address, 0..MAX_LEN-1
- wr_data  in  CHAR_W  character to write
- start  in  1  begin streaming; sampled only in IDLE
- msg_len  in  LEN_W  message length, sampled with start
- msg_label  in  1  ground-truth label, sampled with start (1 = spam)
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the last character is accepted
- err_len  out  1  one-cycle pulse when start is rejected
- out_valid  out  1  character available
- out_ready  in  1  consumer accepts character
- out_data  out  CHAR_W  current character
- out_index  out  LEN_W  position of current character
- out_last  out  1  current character is index msg_len-1
- out_label  out  1  latched label, stable for the whole message

## Operation
- States:
  - IDLE: accepts writes and start.
  - STREAM: presents characters.
  - DONE: one cycle; done=1.
  - DONE → IDLE unconditionally.
- Buffer: MAX_LEN x CHAR_W register array. It is not reset; contents persist across messages.
- Writes:
  - wr_en in IDLE with wr_addr < MAX_LEN writes wr_data.
  - Writes with wr_addr ≥ MAX_LEN, or in any other state, are ignored.
- start in IDLE:
  - 1 ≤ msg_len ≤ MAX_LEN: latch msg_len and msg_label, clear idx, go to STREAM.
  - Otherwise: pulse err_len for one cycle and stay in IDLE.
- Same-cycle wr_en and start in IDLE: the write completes, and the stream reads the updated value.
- STREAM:
  - out_valid=1, out_data=buf[idx], out_index=idx, out_last=(idx==len-1).
  - A handshake (out_valid & out_ready) with out_last=0 increments idx.
  - A handshake with out_last=1 moves to DONE.
- AXI-style rule: once out_valid is high, out_data, out_index, out_last and out_label hold until the handshake. out_valid never drops without a handshake.
- start during STREAM or DONE is ignored and does not raise err_len.

## Timing
- Reset (async assert, sync deassert at the next clk edge):
  - state=IDLE, busy=0, done=0, err_len=0, out_valid=0, out_last=0, out_label=0, out_index=0, out_data=0.
  - Reset mid-stream aborts the message immediately; no done pulse is produced.
- start sampled at edge k:
  - busy=1 and out_valid=1 with character 0 after edge k.
  - err_len, for a rejected start, is high only between edges k and k+1.
- Throughput: with out_ready held high, one character per cycle. An N-character message occupies N cycles in STREAM.
- The last handshake at edge m leads to DONE after m:
  - out_valid=0, done=1, busy=1.
- IDLE after edge m+1, with busy=0. The earliest next start is sampled at edge m+2.
- Latency from start to done: N+1 cycles with no backpressure.
- Outside STREAM, out_data, out_index and out_last read 0. out_label holds its last latched value.

## Test plan
- Reset, then write "abc" (0x61, 0x62, 0x63) at addresses 0..2, start with len=3 and label=1, ready=1 → out_data 0x61/0x62/0x63 on consecutive cycles, out_last only on 0x63, out_label=1, done pulses one cycle later.
- Same message with out_ready toggling 1,0,0,1,1 → each character holds stable while ready=0, and exactly 3 handshakes occur.
- start with msg_len=0, then with msg_len=161 → err_len pulses each time, busy stays 0, out_valid stays 0.
- Length 160 with buf[i]=i, ready=1 → 160 beats with index 0..159, out_last at index 159, done at cycle 161.
- wr_en to address 5 and a second start during STREAM → buffer and stream unaffected; rerunning the message shows the old buf[5].
- Assert reset after beat 2 of 5 → all outputs go to 0 immediately with no done. A fresh start streams from index 0 using the retained buffer.
